// File: rtl/trace_mem_arbiter.sv
// trace_mem_arbiter
//   Owns the single-port trace memory for the 32x24 Light Cycles grid
//   (768 cells x 2 bits: bit0 = player 1 trace, bit1 = player 2 trace).
//   The port is shared between the VGA pixel fetch (highest priority,
//   read only), the game engine read-modify-write and a round-clear sweep.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   vga_req/vga_addr             VGA read request, returns vga_rdata with
//   vga_rdata/vga_rvalid         vga_rvalid one cycle later
//   game_req/game_addr/game_mark game RMW request (level until game_done)
//   game_gnt/game_done/game_old  accept pulse, completion pulse, prior cell
//   clr_start/clr_busy           start a full-grid clear / clear in progress
//   mem_en/mem_we/mem_addr/      synchronous-read block RAM port
//   mem_wdata/mem_rdata
//   stall_cnt                    only with ARB_STALL_CNT_EN: saturating
//                                count of cycles lost to VGA
//
// Build option: define ARB_STALL_CNT_EN to add the stall_cnt output.
module trace_mem_arbiter #(
  parameter int CELLS = 768,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic [1:0]    vga_rdata,
  output logic          vga_rvalid,
  input  logic          game_req,
  input  logic [AW-1:0] game_addr,
  input  logic [1:0]    game_mark,
  output logic          game_gnt,
  output logic          game_done,
  output logic [1:0]    game_old,
  input  logic          clr_start,
  output logic          clr_busy,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_wdata,
  input  logic [1:0]    mem_rdata
);

  typedef enum logic [2:0] {IDLE, G_RD, G_WR, G_DONE, CLR} state_t;

  localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] clr_cnt;
  logic [1:0]    mark_q;
  logic [1:0]    old_q;
  logic          first_q;
  logic          clr_pend;

  logic          on_grid;
  logic          grant;
  logic [1:0]    wr_old;

  // Off-grid cells are walls: they never touch the RAM.
  assign on_grid = ({1'b0, game_addr} < (AW + 1)'(CELLS));

  // A pending or just-requested clear outranks the game in IDLE.
  assign grant = (state == IDLE) && game_req && !vga_req && !clr_pend &&
                 !clr_start && !rst;

  // On the first G_WR cycle the RAM output still holds the game read;
  // later cycles may carry VGA data, so the captured copy is used.
  assign wr_old = first_q ? mem_rdata : old_q;

  assign game_gnt  = grant;
  assign vga_rdata = mem_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (vga_req) begin
        mem_en   = 1'b1;
        mem_addr = vga_addr;
      end else if (grant && on_grid) begin
        mem_en   = 1'b1;
        mem_addr = game_addr;
      end else if (state == G_WR) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wr_old | mark_q;
      end else if (state == CLR) begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clr_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clr_pend   <= 1'b0;
      clr_cnt    <= '0;
      clr_busy   <= 1'b0;
      game_done  <= 1'b0;
      game_old   <= '0;
      vga_rvalid <= 1'b0;
      addr_q     <= '0;
      mark_q     <= '0;
      old_q      <= '0;
      first_q    <= 1'b0;
    end else begin
      vga_rvalid <= vga_req;
      game_done  <= 1'b0;
      if (clr_start) begin
        clr_pend <= 1'b1;
        clr_busy <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (clr_pend || clr_start) begin
            state    <= CLR;
            clr_cnt  <= '0;
            clr_pend <= 1'b0;
          end else if (grant) begin
            addr_q  <= game_addr;
            mark_q  <= game_mark;
            first_q <= 1'b1;
            state   <= on_grid ? G_WR : G_RD;
          end
        end
        // Off-grid request: no RAM traffic, report a wall on schedule.
        G_RD: begin
          game_old  <= 2'b11;
          game_done <= 1'b1;
          state     <= G_DONE;
        end
        G_WR: begin
          first_q <= 1'b0;
          if (first_q) old_q <= mem_rdata;
          if (!vga_req) begin
            game_old  <= wr_old;
            game_done <= 1'b1;
            state     <= G_DONE;
          end
        end
        G_DONE: state <= IDLE;
        CLR: begin
          clr_pend <= 1'b0;
          if (clr_start) begin
            clr_cnt <= '0;
          end else if (!vga_req) begin
            if (clr_cnt == LAST) begin
              state    <= IDLE;
              clr_busy <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic stall;
  assign stall = vga_req && (((state == IDLE) && game_req) ||
                             (state == G_WR) || (state == CLR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (clr_start)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_trace_mem_arbiter.sv
// Testbench for trace_mem_arbiter: block RAM model, directed table of game
// RMW transactions, clear sequences and a randomized phase against a
// grid-level reference model.
module tb_trace_mem_arbiter;
  localparam int CELLS = 768;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [1:0]    vga_rdata;
  logic          vga_rvalid;
  logic          game_req;
  logic [AW-1:0] game_addr;
  logic [1:0]    game_mark;
  logic          game_gnt;
  logic          game_done;
  logic [1:0]    game_old;
  logic          clr_start;
  logic          clr_busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_wdata;
  logic [1:0]    mem_rdata;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
  int            exp_stall;
`endif

  always #5 clk = ~clk;

  trace_mem_arbiter #(.CELLS(CELLS), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_rdata  (vga_rdata),
    .vga_rvalid (vga_rvalid),
    .game_req   (game_req),
    .game_addr  (game_addr),
    .game_mark  (game_mark),
    .game_gnt   (game_gnt),
    .game_done  (game_done),
    .game_old   (game_old),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
`ifdef ARB_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous-read block RAM; ram_fill preloads nonzero garbage.
  logic [1:0] ram [0:1023];
  logic       ram_fill;
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 2'((i % 3) + 1);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [1:0] grid [0:CELLS-1];

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    mark;
    int            nblk;
    logic [1:0]    exp_old;
    int            exp_lat;
  } txn_t;
  txn_t tbl [9];

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    exp;
  } rd_t;
  rd_t rtbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_grid();
    for (int i = 0; i < CELLS; i++) grid[i] = 2'b00;
  endtask

  // Enters and leaves 1 time unit after a rising edge.
  task automatic vga_read(input logic [AW-1:0] a, input logic [1:0] exp);
    vga_req  = 1'b1;
    vga_addr = a;
    #1;
    chk("vga_mem_en", 32'(mem_en), 1);
    chk("vga_mem_we", 32'(mem_we), 0);
    chk("vga_mem_addr", 32'(mem_addr), 32'(a));
    cyc();
    vga_req = 1'b0;
    #1;
    chk("vga_rvalid", 32'(vga_rvalid), 1);
    chk("vga_rdata", 32'(vga_rdata), 32'(exp));
    cyc();
  endtask

  task automatic run_txn(input txn_t t, input logic [AW-1:0] vaddr);
    int            lat;
    int            nwr;
    logic [1:0]    wd;
    logic [AW-1:0] wa;
    bit            seen;
    bit            ongrid;
    ongrid    = (t.addr < AW'(CELLS));
    lat       = 0;
    nwr       = 0;
    wd        = 2'b00;
    wa        = '0;
    seen      = 1'b0;
    game_req  = 1'b1;
    game_addr = t.addr;
    game_mark = t.mark;
    vga_req   = 1'b0;
    #1;
    chk("txn_gnt", 32'(game_gnt), 1);
    chk("txn_rd_en", 32'(mem_en), ongrid ? 1 : 0);
    chk("txn_rd_we", 32'(mem_we), 0);
    for (int k = 1; k <= 20 && !seen; k++) begin
      cyc();
      vga_req  = (k <= t.nblk);
      vga_addr = vaddr;
      #1;
      if (mem_we) begin
        nwr++;
        wd = mem_wdata;
        wa = mem_addr;
      end
      if (game_done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk("txn_done_seen", 32'(seen), 1);
    chk("txn_latency", 32'(lat), 32'(t.exp_lat));
    chk("txn_old", 32'(game_old), 32'(t.exp_old));
    chk("txn_writes", 32'(nwr), ongrid ? 1 : 0);
    if (ongrid) begin
      chk("txn_wdata", 32'(wd), 32'(t.exp_old | t.mark));
      chk("txn_waddr", 32'(wa), 32'(t.addr));
      grid[t.addr] = grid[t.addr] | t.mark;
`ifdef ARB_STALL_CNT_EN
      exp_stall = exp_stall + t.nblk;
`endif
    end
`ifdef ARB_STALL_CNT_EN
    chk("txn_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
    cyc();
    game_req = 1'b0;
    vga_req  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         busy_n;
    int         vga_n;
    bit         got;
    bit         fin;
    bit         act;
    bit         granted;
    bit         pv;
    logic [AW-1:0] taddr;
    logic [1:0] tmark;
    logic [1:0] texp;
    logic [1:0] pexp;
    logic [1:0] palt;
    int         twait;

    tbl[0] = '{addr: 10'd70,   mark: 2'b01, nblk: 0, exp_old: 2'b00, exp_lat: 2};
    tbl[1] = '{addr: 10'd70,   mark: 2'b10, nblk: 0, exp_old: 2'b01, exp_lat: 2};
    tbl[2] = '{addr: 10'd71,   mark: 2'b10, nblk: 5, exp_old: 2'b00, exp_lat: 7};
    tbl[3] = '{addr: 10'd71,   mark: 2'b01, nblk: 1, exp_old: 2'b10, exp_lat: 3};
    tbl[4] = '{addr: 10'd800,  mark: 2'b01, nblk: 0, exp_old: 2'b11, exp_lat: 2};
    tbl[5] = '{addr: 10'd800,  mark: 2'b10, nblk: 3, exp_old: 2'b11, exp_lat: 2};
    tbl[6] = '{addr: 10'd767,  mark: 2'b11, nblk: 2, exp_old: 2'b00, exp_lat: 4};
    tbl[7] = '{addr: 10'd1023, mark: 2'b01, nblk: 0, exp_old: 2'b11, exp_lat: 2};
    tbl[8] = '{addr: 10'd0,    mark: 2'b10, nblk: 0, exp_old: 2'b00, exp_lat: 2};
    rtbl[0] = '{addr: 10'd70,  exp: 2'b11};
    rtbl[1] = '{addr: 10'd71,  exp: 2'b11};
    rtbl[2] = '{addr: 10'd767, exp: 2'b11};
    rtbl[3] = '{addr: 10'd0,   exp: 2'b10};
    rtbl[4] = '{addr: 10'd10,  exp: 2'b01};

    rst       = 1'b1;
    ram_fill  = 1'b1;
    vga_req   = 1'b0;
    vga_addr  = '0;
    game_req  = 1'b0;
    game_addr = '0;
    game_mark = 2'b00;
    clr_start = 1'b0;
`ifdef ARB_STALL_CNT_EN
    exp_stall = 0;
`endif
    repeat (3) cyc();
    ram_fill  = 1'b0;
    vga_req   = 1'b1;
    vga_addr  = 10'd5;
    game_req  = 1'b1;
    game_addr = 10'd5;
    #1;
    chk("rst_game_gnt", 32'(game_gnt), 0);
    chk("rst_game_done", 32'(game_done), 0);
    chk("rst_game_old", 32'(game_old), 0);
    chk("rst_vga_rvalid", 32'(vga_rvalid), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
`ifdef ARB_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
    vga_req  = 1'b0;
    game_req = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    // Clear with a game request held: clear wins, game waits until idle.
    clr_start = 1'b1;
    game_req  = 1'b1;
    game_addr = 10'd10;
    game_mark = 2'b01;
    #1;
    chk("clr_beats_game", 32'(game_gnt), 0);
    cyc();
    clr_start = 1'b0;
    #1;
    chk("clr_busy_rise", 32'(clr_busy), 1);
    busy_n = 0;
    got    = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      if (game_gnt) begin
        got = 1'b1;
        chk("gnt_only_when_not_busy", 32'(clr_busy), 0);
      end else begin
        if (clr_busy) busy_n++;
        cyc();
        #1;
      end
    end
    chk("clr_gnt_after", 32'(got), 1);
    chk("clr_busy_cycles", 32'(busy_n), 768);
    clear_grid();
    cyc();
    #1;
    chk("clr_txn_we", 32'(mem_we), 1);
    chk("clr_txn_wdata", 32'(mem_wdata), 1);
    cyc();
    #1;
    chk("clr_txn_done", 32'(game_done), 1);
    chk("clr_txn_old", 32'(game_old), 0);
    grid[10] = 2'b01;
`ifdef ARB_STALL_CNT_EN
    chk("clr_stall_cnt", 32'(stall_cnt), 0);
`endif
    cyc();
    game_req = 1'b0;

    vga_read(10'd0, 2'b00);
    vga_read(10'd500, 2'b00);
    vga_read(10'd767, 2'b00);
    vga_read(10'd70, 2'b00);

    for (int i = 0; i < 9; i++) run_txn(tbl[i], 10'd300);
    for (int i = 0; i < 5; i++) vga_read(rtbl[i].addr, rtbl[i].exp);

    // Reset during the write cycle of an RMW on cell 5.
    game_req  = 1'b1;
    game_addr = 10'd5;
    game_mark = 2'b01;
    #1;
    chk("rmw_rst_gnt", 32'(game_gnt), 1);
    cyc();
    #1;
    chk("rmw_rst_we_before", 32'(mem_we), 1);
    rst = 1'b1;
    #1;
    chk("rmw_rst_we_after", 32'(mem_we), 0);
    chk("rmw_rst_done", 32'(game_done), 0);
    game_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
`ifdef ARB_STALL_CNT_EN
    exp_stall = 0;
`endif
    cyc();
    #1;
    chk("rmw_rst_no_done", 32'(game_done), 0);
    cyc();
    vga_read(10'd5, 2'b00);

    // Clear requested mid-RMW: the RMW completes, then the sweep runs.
    game_req  = 1'b1;
    game_addr = 10'd20;
    game_mark = 2'b10;
    #1;
    chk("pend_gnt", 32'(game_gnt), 1);
    cyc();
    clr_start = 1'b1;
    #1;
    chk("pend_rmw_we", 32'(mem_we), 1);
    cyc();
    clr_start = 1'b0;
    #1;
    chk("pend_busy", 32'(clr_busy), 1);
    chk("pend_done", 32'(game_done), 1);
    chk("pend_old", 32'(game_old), 0);
    cyc();
    game_req = 1'b0;
    #1;
    fin = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      if (!clr_busy) fin = 1'b1;
      else begin
        cyc();
        #1;
      end
    end
    chk("pend_clear_ends", 32'(fin), 1);
    clear_grid();
`ifdef ARB_STALL_CNT_EN
    exp_stall = 0;
    chk("pend_stall_cnt", 32'(stall_cnt), 0);
`endif
    cyc();
    vga_read(10'd20, 2'b00);
    vga_read(10'd5, 2'b00);

    // Clear under random VGA traffic, restarted part-way through.
    clr_start = 1'b1;
    #1;
    cyc();
    busy_n = 0;
    vga_n  = 0;
    fin    = 1'b0;
    for (int k = 0; k < 6000 && !fin; k++) begin
      clr_start = (k == 150);
      vga_req   = (k == 150) ? 1'b0 : ($urandom_range(2) == 0);
      vga_addr  = AW'($urandom_range(767));
      #1;
      if (!clr_busy) fin = 1'b1;
      else begin
        if (k > 150) begin
          busy_n++;
          if (vga_req) vga_n++;
        end
        cyc();
      end
    end
    chk("rclr_ends", 32'(fin), 1);
    chk("rclr_busy_cycles", 32'(busy_n), 32'(768 + vga_n));
`ifdef ARB_STALL_CNT_EN
    chk("rclr_stall_cnt", 32'(stall_cnt), 32'(vga_n));
`endif
    cyc();
    vga_req   = 1'b0;
    clr_start = 1'b0;
    clear_grid();
    cyc();

    // Randomized traffic against the grid model.
    act     = 1'b0;
    granted = 1'b0;
    pv      = 1'b0;
    taddr   = '0;
    tmark   = 2'b00;
    texp    = 2'b00;
    pexp    = 2'b00;
    palt    = 2'b00;
    twait   = 0;
    for (int c = 0; c < 3040; c++) begin
      if (pv) begin
        chk("rnd_rvalid", 32'(vga_rvalid), 1);
        checks++;
        if (!(vga_rdata === pexp || vga_rdata === palt)) begin
          errors++;
          $display("FAIL rnd_rdata: got %0h expected %0h or %0h", vga_rdata, pexp, palt);
        end
      end
      if (!act) begin
        if (c < 3000 && $urandom_range(3) == 0) begin
          act       = 1'b1;
          granted   = 1'b0;
          twait     = 0;
          taddr     = AW'($urandom_range(799));
          tmark     = 2'($urandom_range(3, 1));
          game_req  = 1'b1;
          game_addr = taddr;
          game_mark = tmark;
        end else begin
          game_req = 1'b0;
        end
      end
      vga_req  = (c < 3000) && ($urandom_range(2) == 0);
      vga_addr = AW'($urandom_range(767));
      #1;
      if (vga_req) begin
        chk("rnd_vga_en", 32'(mem_en), 1);
        chk("rnd_vga_we", 32'(mem_we), 0);
        chk("rnd_vga_addr", 32'(mem_addr), 32'(vga_addr));
      end
      if (act) begin
        twait++;
        if (game_gnt) begin
          chk("rnd_gnt_once", 32'(granted), 0);
          chk("rnd_gnt_no_vga", 32'(vga_req), 0);
          granted = 1'b1;
          texp    = (taddr < AW'(CELLS)) ? grid[taddr] : 2'b11;
        end
        if (game_done) begin
          chk("rnd_done_after_gnt", 32'(granted), 1);
          chk("rnd_old", 32'(game_old), 32'(texp));
          if (taddr < AW'(CELLS)) grid[taddr] = grid[taddr] | tmark;
          act = 1'b0;
        end else if (twait > 60) begin
          chk("rnd_txn_timeout", 32'(twait), 0);
          act = 1'b0;
        end
      end
      pv   = vga_req;
      pexp = grid[vga_addr];
      palt = (act && granted && taddr == vga_addr) ? (grid[vga_addr] | tmark) : pexp;
      cyc();
    end
    chk("rnd_drained", 32'(act), 0);
    game_req = 1'b0;
    vga_req  = 1'b0;
    cyc();

    for (int i = 0; i < CELLS; i++) vga_read(AW'(i), grid[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_mem_arbiter.md
Name: trace_mem_arbiter

Overview:
- Owns the single-port trace memory that holds the 32x24 Light Cycles grid: 768 cells, 2 bits each (bit0 = player 1 trace, bit1 = player 2 trace).
- Shares the memory between three requesters: the VGA pixel fetch (read-only, highest priority), the game engine (read-modify-write with collision return), and a round-clear sweep (lowest priority).
- Sits between the game logic, the VGA timing block and a synchronous-read block RAM.

Parameters:
- CELLS, 768, number of valid grid cells; addresses >= CELLS are off-grid.
- AW, 10, address width of all address ports.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- vga_req  in  1  VGA read request for this cycle
- vga_addr  in  AW  VGA cell address
- vga_rdata  out  2  cell data; mem_rdata passed through
- vga_rvalid  out  1  vga_rdata valid; high the cycle after an accepted vga_req
- game_req  in  1  game RMW request; level, held until game_done
- game_addr  in  AW  cell to test and mark
- game_mark  in  2  bits to OR into the cell
- game_gnt  out  1  one-cycle pulse when the request is accepted (addr/mark latched)
- game_done  out  1  one-cycle pulse when the RMW completes
- game_old  out  2  cell contents before the write; valid with game_done, held until the next done
- clr_start  in  1  pulse: zero all CELLS cells
- clr_busy  out  1  high while a clear is pending or running
- mem_en, mem_we  out  1 each  RAM enable / write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  2  RAM write data
- mem_rdata  in  2  RAM read data; 1-cycle latency after mem_en with !mem_we

Behaviour:
- Reset: FSM to IDLE; clears pending-clear flag and clear counter. All outputs 0: game_gnt, game_done, game_old, vga_rvalid, clr_busy, mem_en, mem_we. RAM contents are untouched (a clear is needed).
- Reset mid-operation aborts any RMW or clear immediately. No partial write is issued after rst rises.
- Port priority every cycle:
  - vga_req present: VGA owns the port (mem_en=1, mem_we=0, mem_addr=vga_addr); vga_rvalid=1 the next cycle.
  - Otherwise the pending game phase or the clear step uses the port.
- FSM states: IDLE, G_RD, G_WR, G_DONE, CLR.
- IDLE transitions:
  - Clear pending -> CLR.
  - Else game_req && !vga_req -> issue read of game_addr this cycle, pulse game_gnt, latch addr/mark, go to G_WR.
  - game_req while vga_req is high -> wait in IDLE; no gnt.
- G_WR:
  - mem_rdata is captured into old_q on the first G_WR cycle unconditionally.
  - Write old_q|mark when the port is free; the first cycle uses mem_rdata|mark directly.
  - If vga_req blocks, stay in G_WR holding old_q.
  - After the write -> G_DONE.
- G_DONE: pulse game_done, drive game_old=old_q, return to IDLE. Nominal latency is gnt at T, write at T+1, done at T+2.
- Off-grid game_addr (>= CELLS): gnt pulses, no RAM access, done at T+2 with game_old=2'b11 (wall = collision).
- Clear:
  - clr_start sets the pending flag and clr_busy at once.
  - It is honoured in IDLE only; an in-flight RMW finishes first.
  - CLR writes 0 to address 0..CELLS-1, one cell per cycle the port is free of VGA. Afterwards clr_busy drops and the FSM returns to IDLE.
  - game_req is not granted while clr_busy.
  - clr_start during CLR restarts the sweep at address 0.
- Simultaneous clr_start and game_req in IDLE: clear wins.
- Counter and address arithmetic is unsigned AW-bit. The clear counter stops at CELLS-1 and never wraps.

Optional Feature:
- Macro ARB_STALL_CNT_EN.
- Defined: adds output stall_cnt[15:0]. It counts cycles in which IDLE(with game_req), G_WR or CLR was blocked by vga_req. It saturates at 16'hFFFF and is cleared by rst or clr_start.
- Undefined: the port and the counter are absent; arbitration is otherwise identical.

Test Plan:
- Reset -> all outputs 0, FSM idle. Pulse clr_start with no VGA -> clr_busy for exactly 768 cycles; VGA reads of addr 0, 500, 767 return 00.
- VGA read of addr 70 at T -> mem_en=1, mem_we=0 at T; vga_rvalid=1 at T+1 with cell data.
- Empty cell 70, game_addr=70, mark=01, no VGA -> gnt T, write 01 at T+1, done T+2 with old=00. Then mark=10 on 70 -> old=01 and the cell becomes 11.
- Game RMW with vga_req held high for 5 cycles starting at T+1 -> old still 00 (captured T+1), write delayed to T+6, done T+7. With ARB_STALL_CNT_EN, stall_cnt=5.
- game_addr=800 -> gnt, done two cycles later, old=11; no mem_we ever asserted.
- rst asserted on the G_WR cycle -> mem_we low immediately, no done; cell is unchanged after reset.
